// File: rtl/masked_merge_regfile.sv
// Multi-entry wide register file with NPORTS bit-masked write ports.
// Init sweep after reset/clear, registered read, collision count, address errors.
module masked_merge_regfile #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4,
  parameter int NPORTS = 2,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter logic [WIDTH-1:0] INIT_VALUE = {WIDTH{1'b1}},
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [NPORTS-1:0]        wr_en,
  input  logic [NPORTS*ADDR_W-1:0] wr_addr,
  input  logic [NPORTS*WIDTH-1:0]  wr_data,
  input  logic [NPORTS*WIDTH-1:0]  wr_mask,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     ready,
  output logic [CNT_W-1:0]         collision_cnt,
  output logic                     addr_err
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_ptr, init_ptr_nxt;
  logic              ready_nxt;

  logic [WIDTH-1:0]  mem     [DEPTH];
  logic [WIDTH-1:0]  mem_nxt [DEPTH];

  logic [ADDR_W-1:0] wa [NPORTS];
  logic [WIDTH-1:0]  wd [NPORTS];
  logic [WIDTH-1:0]  wm [NPORTS];
  logic [NPORTS-1:0] wr_ok, wr_act;

  logic              accept, rd_ok, coll, bad_acc;
  logic [WIDTH-1:0]  rd_mux;

  // clear cycle drops every access presented with it
  assign accept = (state == S_RUN) && !clear;
  assign rd_ok  = 32'(rd_addr) < 32'(DEPTH);

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      wa[p]     = wr_addr[p*ADDR_W +: ADDR_W];
      wd[p]     = wr_data[p*WIDTH +: WIDTH];
      wm[p]     = wr_mask[p*WIDTH +: WIDTH];
      wr_ok[p]  = 32'(wa[p]) < 32'(DEPTH);
      wr_act[p] = accept && wr_en[p] && wr_ok[p];
    end
  end

  // ascending port order: highest enabled port wins each contested bit
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      mem_nxt[e] = mem[e];
      if (state == S_INIT) begin
        if (init_ptr == ADDR_W'(e)) mem_nxt[e] = INIT_VALUE;
      end else begin
        for (int p = 0; p < NPORTS; p++) begin
          if (wr_act[p] && wa[p] == ADDR_W'(e))
            mem_nxt[e] = (mem_nxt[e] & ~wm[p]) | (wd[p] & wm[p]);
        end
      end
    end
  end

  always_comb begin
    coll = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      for (int q = p + 1; q < NPORTS; q++) begin
        if (wr_act[p] && wr_act[q] && wa[p] == wa[q] && |(wm[p] & wm[q]))
          coll = 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (rd_addr == ADDR_W'(e)) rd_mux = mem[e];
    end
  end

  assign bad_acc = accept && ((|(wr_en & ~wr_ok)) || (rd_en && !rd_ok));

  always_comb begin
    state_nxt    = state;
    init_ptr_nxt = init_ptr;
    ready_nxt    = ready;
    unique case (state)
      S_INIT: begin
        init_ptr_nxt = init_ptr + ADDR_W'(1);
        if (init_ptr == ADDR_W'(DEPTH - 1)) begin
          state_nxt    = S_RUN;
          init_ptr_nxt = '0;
          ready_nxt    = 1'b1;
        end
      end
      S_RUN: begin
        if (clear) begin
          state_nxt    = S_INIT;
          init_ptr_nxt = '0;
          ready_nxt    = 1'b0;
        end
      end
    endcase
  end

  // storage has no reset; the sweep initialises it
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) mem[e] <= mem_nxt[e];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_INIT;
      init_ptr      <= '0;
      ready         <= 1'b0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      collision_cnt <= '0;
      addr_err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_ptr <= init_ptr_nxt;
      ready    <= ready_nxt;
      rd_valid <= accept && rd_en;
      if (accept && rd_en) rd_data <= rd_ok ? rd_mux : '0;
      if (coll && collision_cnt != {CNT_W{1'b1}})
        collision_cnt <= collision_cnt + CNT_W'(1);
      if (bad_acc) addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_masked_merge_regfile.sv
// Scoreboard bench for masked_merge_regfile.
// Two instances: DEPTH=4 default, DEPTH=6 with a narrow collision counter.
module tb_masked_merge_regfile;
  localparam int W = 128;
  localparam int NP = 2;
  localparam int AW = 2;
  localparam int AW6 = 3;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             clear, rd_en, rd_valid, ready, addr_err;
  logic [NP-1:0]    wr_en;
  logic [NP*AW-1:0] wr_addr;
  logic [NP*W-1:0]  wr_data, wr_mask;
  logic [AW-1:0]    rd_addr;
  logic [W-1:0]     rd_data;
  logic [15:0]      collision_cnt;

  logic              clear6, rd_en6, rd_valid6, ready6, addr_err6;
  logic [NP-1:0]     wr_en6;
  logic [NP*AW6-1:0] wr_addr6;
  logic [NP*W-1:0]   wr_data6, wr_mask6;
  logic [AW6-1:0]    rd_addr6;
  logic [W-1:0]      rd_data6;
  logic [1:0]        collision_cnt6;

  masked_merge_regfile dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .ready(ready),
    .collision_cnt(collision_cnt), .addr_err(addr_err)
  );

  masked_merge_regfile #(.DEPTH(6), .ADDR_W(3), .CNT_W(2)) dut6 (
    .clk(clk), .rst_n(rst_n), .clear(clear6),
    .wr_en(wr_en6), .wr_addr(wr_addr6), .wr_data(wr_data6),
    .wr_mask(wr_mask6), .rd_en(rd_en6), .rd_addr(rd_addr6),
    .rd_data(rd_data6), .rd_valid(rd_valid6), .ready(ready6),
    .collision_cnt(collision_cnt6), .addr_err(addr_err6)
  );

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp6_q[$];
  logic [W-1:0] ev, ev6;

  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_spurious got=%h want=no_read", rd_data);
      end else begin
        ev = exp_q.pop_front();
        if (rd_data !== ev) begin
          bad++;
          $display("FAIL rd_data got=%h want=%h", rd_data, ev);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rd_valid6) begin
      total++;
      if (exp6_q.size() == 0) begin
        bad++;
        $display("FAIL rd6_spurious got=%h want=no_read", rd_data6);
      end else begin
        ev6 = exp6_q.pop_front();
        if (rd_data6 !== ev6) begin
          bad++;
          $display("FAIL rd6_data got=%h want=%h", rd_data6, ev6);
        end
      end
    end
  end

  task automatic idle();
    clear = 0; wr_en = '0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rd_en = 0; rd_addr = '0;
    clear6 = 0; wr_en6 = '0; wr_addr6 = '0; wr_data6 = '0; wr_mask6 = '0;
    rd_en6 = 0; rd_addr6 = '0;
  endtask

  task automatic set_port(int p, logic [AW-1:0] a, logic [W-1:0] d, logic [W-1:0] m);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*W +: W] = d;
    wr_mask[p*W +: W] = m;
  endtask

  task automatic set_port6(int p, logic [AW6-1:0] a, logic [W-1:0] d, logic [W-1:0] m);
    wr_en6[p] = 1'b1;
    wr_addr6[p*AW6 +: AW6] = a;
    wr_data6[p*W +: W] = d;
    wr_mask6[p*W +: W] = m;
  endtask

  task automatic do_read(logic [AW-1:0] a, logic [W-1:0] e);
    exp_q.push_back(e);
    rd_en = 1; rd_addr = a;
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic do_read6(logic [AW6-1:0] a, logic [W-1:0] e);
    exp6_q.push_back(e);
    rd_en6 = 1; rd_addr6 = a;
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    repeat (3) @(negedge clk);
    total++;
    if (ready !== 0 || rd_valid !== 0 || collision_cnt !== 0 ||
        addr_err !== 0 || rd_data !== '0) begin
      bad++;
      $display("FAIL reset_vals got=%b%b%h%b%h want=0", ready, rd_valid,
               collision_cnt, addr_err, rd_data);
    end
    rst_n = 1;
    rd_en = 1; rd_addr = 2;
    total++;
    if (ready !== 0) begin
      bad++; $display("FAIL ready_at_release got=%b want=0", ready);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      total++;
      if (ready !== (i == 4)) begin
        bad++;
        $display("FAIL ready_sweep%0d got=%b want=%b", i, ready, i == 4);
      end
    end
    idle();
  endtask

  task automatic test_read_init();
    do_read(2, ONES);
    total++;
    if (exp_q.size() != 0 || rd_valid !== 0) begin
      bad++;
      $display("FAIL read_init_pulse got=%0d/%b want=0/0", exp_q.size(), rd_valid);
    end
  endtask

  task automatic test_collision();
    set_port(0, 0, ONES, ONES);
    set_port(1, 0, '0, {1'b1, {(W-1){1'b0}}});
    @(negedge clk);
    idle();
    do_read(0, {1'b0, {(W-1){1'b1}}});
    total++;
    if (collision_cnt !== 16'd1) begin
      bad++; $display("FAIL coll_cnt got=%0d want=1", collision_cnt);
    end
  endtask

  task automatic test_disjoint();
    set_port(0, 1, {64'h0, 64'h0123_4567_89AB_CDEF}, {64'h0, {64{1'b1}}});
    set_port(1, 1, {64'hDEAD_BEEF_CAFE_F00D, 64'h0}, {{64{1'b1}}, 64'h0});
    @(negedge clk);
    idle();
    do_read(1, {64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF});
    total++;
    if (collision_cnt !== 16'd1) begin
      bad++; $display("FAIL disjoint_cnt got=%0d want=1", collision_cnt);
    end
  endtask

  task automatic test_rbw();
    set_port(0, 3, '0, ONES);
    do_read(3, ONES);
    do_read(3, '0);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL rbw_pending got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_clear();
    clear = 1;
    set_port(0, 2, '0, ONES);
    rd_en = 1; rd_addr = 2;
    @(negedge clk);
    idle();
    total++;
    if (ready !== 0) begin
      bad++; $display("FAIL clear_ready got=%b want=0", ready);
    end
    for (int i = 1; i <= 4; i++) begin
      set_port(0, 0, '0, ONES);
      set_port(1, 1, '0, ONES);
      @(negedge clk);
      idle();
      total++;
      if (ready !== (i == 4)) begin
        bad++;
        $display("FAIL clear_sweep%0d got=%b want=%b", i, ready, i == 4);
      end
    end
    for (int e = 0; e < 4; e++) do_read(AW'(e), ONES);
    total++;
    if (collision_cnt !== 16'd1 || addr_err !== 0) begin
      bad++;
      $display("FAIL clear_keep got=%0d/%b want=1/0", collision_cnt, addr_err);
    end
  endtask

  task automatic test_addr_err();
    int n = 0;
    while (ready6 !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    total++;
    if (ready6 !== 1'b1 || addr_err6 !== 0) begin
      bad++; $display("FAIL d6_ready got=%b/%b want=1/0", ready6, addr_err6);
    end
    set_port6(0, 7, '0, ONES);
    set_port6(1, 7, '0, ONES);
    @(negedge clk);
    idle();
    total++;
    if (addr_err6 !== 1 || collision_cnt6 !== 2'd0) begin
      bad++;
      $display("FAIL oor_write got=%b/%0d want=1/0", addr_err6, collision_cnt6);
    end
    do_read6(6, '0);
    for (int e = 0; e < 6; e++) do_read6(AW6'(e), ONES);
    total++;
    if (addr_err6 !== 1 || exp6_q.size() != 0) begin
      bad++;
      $display("FAIL oor_sticky got=%b/%0d want=1/0", addr_err6, exp6_q.size());
    end
  endtask

  task automatic test_saturate();
    for (int i = 1; i <= 5; i++) begin
      set_port6(0, 5, '0, ONES);
      set_port6(1, 5, ONES, ONES);
      @(negedge clk);
      idle();
      total++;
      if (collision_cnt6 !== ((i < 3) ? 2'(i) : 2'd3)) begin
        bad++; $display("FAIL sat%0d got=%0d want=%0d", i, collision_cnt6,
                        (i < 3) ? i : 3);
      end
    end
  endtask

  task automatic test_reset_again();
    rst_n = 0;
    #1;
    total++;
    if (addr_err6 !== 0 || collision_cnt6 !== 0 || ready !== 0 || ready6 !== 0) begin
      bad++;
      $display("FAIL rereset got=%b/%0d/%b/%b want=0", addr_err6,
               collision_cnt6, ready, ready6);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_read_init();
    test_collision();
    test_disjoint();
    test_rbw();
    test_clear();
    test_addr_err();
    test_saturate();
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || exp6_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d/%0d want=0/0", exp_q.size(), exp6_q.size());
    end
    test_reset_again();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/masked_merge_regfile.md
Name: masked_merge_regfile

Overview:
Parametrised multi-entry wide register file with NPORTS same-cycle bit-masked write ports.
- Same-cycle writes to one entry merge per bit; the highest-numbered enabled port wins each contested bit, matching last-nonblocking-assignment-wins semantics.
- Adds a post-reset/clear initialisation sweep, a registered read port, overlap (collision) counting and address-error flagging.
- Used as the shared wide state store for scheduler-ordering tests.

Parameters:
WIDTH, 128, data width per entry
DEPTH, 4, number of entries (need not be a power of two)
NPORTS, 2, number of write ports
ADDR_W, $clog2(DEPTH) (minimum 1), address width
INIT_VALUE, {WIDTH{1'b1}}, value every entry holds after init sweep
CNT_W, 16, collision counter width

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous request to re-run init sweep
wr_en  input  NPORTS  per-port write enable
wr_addr  input  NPORTS*ADDR_W  per-port entry address, port p at [p*ADDR_W +: ADDR_W]
wr_data  input  NPORTS*WIDTH  per-port write data
wr_mask  input  NPORTS*WIDTH  per-port bit mask, 1 = bit written
rd_en  input  1  read request
rd_addr  input  ADDR_W  read address
rd_data  output  WIDTH  read result, registered
rd_valid  output  1  one-cycle pulse qualifying rd_data
ready  output  1  high when in RUN state
collision_cnt  output  CNT_W  saturating count of cycles with overlapping writes
addr_err  output  1  sticky flag for any out-of-range access

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_data=0, rd_valid=0, ready=0, collision_cnt=0, addr_err=0.
  - FSM=INIT, init_ptr=0.
  - Array is not reset directly; the sweep initialises it.
- INIT state:
  - Each posedge writes INIT_VALUE to entry init_ptr, then init_ptr++.
  - On the posedge writing entry DEPTH-1: FSM goes to RUN and ready is registered 1. ready is therefore high after exactly DEPTH posedges following reset release.
  - While in INIT, wr_en, rd_en and clear are ignored; rd_valid stays 0.
- RUN state, write merge per entry e:
  - Start with new=old.
  - For p=0..NPORTS-1 ascending: if wr_en[p] and wr_addr[p]==e, then new=(new & ~wr_mask[p]) | (wr_data[p] & wr_mask[p]).
  - Result is registered at posedge. Bits with no mask bit set keep their old value.
- Collision:
  - A cycle counts if at least two enabled in-range ports target the same address with a nonzero mask AND.
  - collision_cnt increments by 1 per such cycle regardless of the number of pairs, and saturates at 2^CNT_W-1.
- Read:
  - rd_en in RUN: next posedge loads rd_data with the pre-write contents of rd_addr (read-before-write for a same-cycle write) and pulses rd_valid.
  - rd_data holds its value between reads.
- Out-of-range address (>=DEPTH):
  - A write port with such an address is dropped: it does not merge and does not count toward collisions.
  - A read with such an address returns 0 with rd_valid=1.
  - Either case sets addr_err, which clears only on reset.
- clear (RUN only):
  - All writes and reads presented in the clear cycle are dropped.
  - Next posedge: FSM=INIT, init_ptr=0, ready=0.
  - collision_cnt and addr_err are preserved.
- rst_n asserted mid-sweep or mid-write: immediate return to reset values; a partial write is not guaranteed to land.

Test Plan:
1. Release reset, DEPTH=4 -> ready=0 for 4 posedges, then 1. Read entry 2 -> rd_data=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, rd_valid pulses once.
2. Same cycle: port0 writes entry 0 with data all-ones, mask all-ones; port1 writes entry 0 with data 0, mask bit127 only -> read returns 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, collision_cnt=1.
3. Disjoint masks on entry 1: port0 writes low 64 bits = 64'h0123_4567_89AB_CDEF, port1 writes high 64 bits = 64'hDEAD_BEEF_CAFE_F00D -> read returns 128'hDEADBEEFCAFEF00D_0123456789ABCDEF, collision_cnt unchanged.
4. rd_en on entry 3 in the same cycle that entry 3 is written with 0 -> rd_data=old value (all-ones). The next read returns 0.
5. Pulse clear with a write presented in the same cycle -> ready=0 for 4 cycles; writes during INIT are ignored; all entries read back all-ones; the write from the clear cycle is absent.
6. DEPTH=6, ADDR_W=3: write to address 7 and read address 6 -> no entry changes, read returns 0 with rd_valid=1, addr_err=1 and stays 1 until rst_n low.
